// File: rtl/vscale_mul_div_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit and its decoder.
// Optional abort support is enabled by defining VSCALE_MD_KILL_EN.
package vscale_mul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FIXUP   = 2'd2,
        ST_DONE    = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input md_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic md_in1_signed(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic md_in2_signed(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/vscale_mul_div.sv
// Radix-2 iterative multiply/divide unit: one bit per cycle on sign-stripped magnitudes.
// Define VSCALE_MD_KILL_EN to add the kill input that aborts an in-flight operation.
module vscale_mul_div
    import vscale_mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_in1,
    input  logic [XLEN-1:0] req_in2,
`ifdef VSCALE_MD_KILL_EN
    input  logic            kill,
`endif
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    md_op_e            op_in;
    logic              sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_top, div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fix_result;

    // Operand preparation at accept time.
    always_comb begin
        op_in    = md_op_e'(req_op);
        sign1    = md_in1_signed(op_in) & req_in1[XLEN-1];
        sign2    = md_in2_signed(op_in) & req_in2[XLEN-1];
        mag1     = sign1 ? (~req_in1 + 1'b1) : req_in1;
        mag2     = sign2 ? (~req_in2 + 1'b1) : req_in2;
        div_zero = (req_in2 == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (req_in1 == MOST_NEG) && (req_in2 == '1);
    end

    // Shift-add step: multiplier sits in the low half and drains out as the product shifts in.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
    end

    // Restoring divide step: partial remainder in the high half, quotient bits enter at the bottom.
    always_comb begin
        div_top  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_top - {1'b0, opnd_q};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d  = op_in;
                    cnt_d = '0;
                    if (md_is_div(op_in)) begin
                        opnd_d = mag2;
                        acc_d  = {{XLEN{1'b0}}, mag1};
                    end else begin
                        opnd_d = mag1;
                        acc_d  = {{XLEN{1'b0}}, mag2};
                    end
                    neg_d = md_is_rem(op_in) ? sign1 : (sign1 ^ sign2);
                    if (md_is_div(op_in) && div_zero) begin
                        result_d = md_is_rem(op_in) ? req_in1 : '1;
                        state_d  = ST_DONE;
                    end else if (div_ovf) begin
                        result_d = md_is_rem(op_in) ? '0 : req_in1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                acc_d = md_is_div(op_q) ? div_next : mul_next;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIXUP: begin
                result_d = fix_result;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef VSCALE_MD_KILL_EN
        // Abort wins over every other transition, including the DONE handshake.
        if (kill && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_DONE);
    assign resp_result = result_q;

endmodule

// File: tb/tb_vscale_mul_div.sv
// Directed bench for vscale_mul_div: arithmetic results, response latency, backpressure and reset abort.
module tb_vscale_mul_div;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = 3'd0;
    logic [XLEN-1:0] req_in1 = '0;
    logic [XLEN-1:0] req_in2 = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_result;
`ifdef VSCALE_MD_KILL_EN
    logic            kill = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vscale_mul_div #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_in1     (req_in1),
        .req_in2     (req_in2),
`ifdef VSCALE_MD_KILL_EN
        .kill        (kill),
`endif
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request at a falling edge; it is accepted on the next rising edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_in1   = a;
        req_in2   = b;
        check("ready_before_accept", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy_after_accept", req_ready, 1'b0);
    endtask

    // Latency 1 means resp_valid is already up in the cycle right after the accept edge.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("idle_after_handshake", req_ready, 1'b1);
        check("valid_drop_after_handshake", resp_valid, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        start_op(op, a, b);
        wait_resp(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, resp_result, exp);
        $display("op=%0d in1=%h in2=%h result=%h latency=%0d (%s)", op, a, b, resp_result, lat, tag);
        finish_resp();
    endtask

    initial begin
        int lat;
        int seen;

        #2;
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_resp_result", resp_result, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_req_ready", req_ready, 1'b1);

        run_op("mul_7_x_m3",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulhu_max",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulhsu_max",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("mulh_minsq",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
        run_op("div_7_m3",       3'd4, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34);
        run_op("rem_7_m3",       3'd6, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0001, 34);
        run_op("remu_100_7",     3'd7, 32'd100,       32'd7,         32'd2,         34);
        run_op("divu_5_0",       3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("div_m5_0",       3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        run_op("rem_9_0",        3'd6, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1);
        run_op("rem_ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("div_ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Backpressure: result must hold for ten cycles, and a request offered during the
        // handshake cycle is only taken on the following edge.
        start_op(3'd0, 32'd3, 32'd4);
        wait_resp(lat);
        check("bp_latency", lat, 34);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", resp_result, 32'd12);
            check("bp_hold_valid", resp_valid, 1'b1);
            check("bp_ready_low", req_ready, 1'b0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = 3'd5;
        req_in1    = 32'd100;
        req_in2    = 32'd7;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp_no_accept_on_handshake", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_next_accepted", req_ready, 1'b0);
        wait_resp(lat);
        check("bp_next_latency", lat, 34);
        check("bp_next_result", resp_result, 32'd14);
        $display("op=5 in1=%h in2=%h result=%h latency=%0d (after backpressure)", 32'd100, 32'd7, resp_result, lat);
        finish_resp();

        // Asynchronous reset mid-multiply discards the operation.
        start_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (16) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", resp_valid, 1'b0);
        check("rst_mid_result", resp_result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_mid_ready", req_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("rst_mid_no_resp", seen, 0);
        $display("op=0 in1=%h in2=%h aborted by reset", 32'h7, 32'hFFFF_FFFD);
        run_op("post_reset_mul", 3'd0, 32'd6, 32'd7, 32'd42, 34);

`ifdef VSCALE_MD_KILL_EN
        start_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (16) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_ready", req_ready, 1'b1);
        check("kill_valid", resp_valid, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("kill_no_resp", seen, 0);
        $display("op=0 in1=%h in2=%h aborted by kill", 32'h7, 32'hFFFF_FFFD);
        run_op("post_kill_divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
